// File: rtl/bw_ctu_clk_div_gen_pkg.sv
// Shared definitions for the CTU clock-divider enable generator:
// FSM state encoding, default counter width and the smallest legal ratio.
package bw_ctu_clk_div_gen_pkg;

  localparam int CNT_W_DEF = 5;
  localparam int MIN_RATIO = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } div_state_e;

endpackage

// File: rtl/bw_ctu_clk_div_gen.sv
// CTU clock-divider enable generator.
// Produces registered div0/div1 enables that a downstream sync-mux combines
// into a 50%-duty divided clock. The divide ratio is loaded through a
// vld/rdy handshake and only ever changes on a period boundary.
// Optional feature: define BW_CTU_CLK_DIV_ALIGN_EN to add the div_align
// output, a one-cycle pulse on the first cycle (cnt==0) of every period.
module bw_ctu_clk_div_gen
  import bw_ctu_clk_div_gen_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RST_RATIO = 2
) (
  input  logic             pll_clk_out,
  input  logic             arst_l,
  input  logic             div_en,
  input  logic             cfg_vld,
  input  logic [CNT_W-1:0] cfg_ratio,
  output logic             cfg_rdy,
  output logic             cfg_err,
  output logic             div0,
  output logic             div1,
  output logic             div_active
`ifdef BW_CTU_CLK_DIV_ALIGN_EN
  ,
  output logic             div_align
`endif
);

  localparam logic [CNT_W-1:0] MIN_RATIO_W = CNT_W'(MIN_RATIO);
  localparam logic [CNT_W-1:0] RST_RATIO_W = CNT_W'(RST_RATIO);
  localparam logic [CNT_W-1:0] ONE_W       = CNT_W'(1);

  div_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] ratio_reg, ratio_next;
  logic [CNT_W-1:0] pend_ratio_reg, pend_ratio_next;
  logic             pend_reg, pend_next;
  logic             div0_reg, div0_next;
  logic             div1_reg, div1_next;
  logic             cfg_err_reg, cfg_err_next;
`ifdef BW_CTU_CLK_DIV_ALIGN_EN
  logic             align_reg, align_next;
`endif

  logic             accept;
  logic             legal;
  logic             wrap;
  logic             active_next;
  logic [CNT_W-1:0] half_next;

  // Handshake and period-boundary decode from the current registered state.
  assign accept = cfg_vld & ~pend_reg;
  assign legal  = (cfg_ratio >= MIN_RATIO_W);
  assign wrap   = (cnt_reg == (ratio_reg - ONE_W));

  // Next state, count, ratio bookkeeping and the enables for the next cycle.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    ratio_next      = ratio_reg;
    pend_ratio_next = pend_ratio_reg;
    pend_next       = pend_reg;
    cfg_err_next    = accept & ~legal;

    case (state_reg)
      ST_IDLE: begin
        // Divider stopped: a legal ratio takes effect immediately.
        if (accept && legal) begin
          ratio_next = cfg_ratio;
        end
        if (div_en) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (wrap) begin
          cnt_next = '0;
          // A held ratio is only swapped in on a period boundary.
          if (pend_reg) begin
            ratio_next = pend_ratio_reg;
            pend_next  = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + ONE_W;
        end
        // pend_reg is clear whenever accept is set, so this never races
        // the clear above; a ratio taken on a wrap waits a full period.
        if (accept && legal) begin
          pend_next       = 1'b1;
          pend_ratio_next = cfg_ratio;
        end
        if (state_reg == ST_RUN) begin
          if (!div_en) begin
            state_next = ST_DRAIN;
          end
        end else begin
          if (div_en) begin
            state_next = ST_RUN;
          end else if (wrap) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    active_next = (state_next != ST_IDLE);
    half_next   = ratio_next >> 1;
    div0_next   = active_next && (cnt_next < half_next);
    div1_next   = div0_next && ratio_next[0];
`ifdef BW_CTU_CLK_DIV_ALIGN_EN
    align_next  = active_next && (cnt_next == '0);
`endif
  end

  // State, counter, ratio and output registers with asynchronous reset.
  always_ff @(posedge pll_clk_out or negedge arst_l) begin
    if (!arst_l) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      ratio_reg      <= RST_RATIO_W;
      pend_ratio_reg <= '0;
      pend_reg       <= 1'b0;
      div0_reg       <= 1'b0;
      div1_reg       <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      ratio_reg      <= ratio_next;
      pend_ratio_reg <= pend_ratio_next;
      pend_reg       <= pend_next;
      div0_reg       <= div0_next;
      div1_reg       <= div1_next;
      cfg_err_reg    <= cfg_err_next;
    end
  end

`ifdef BW_CTU_CLK_DIV_ALIGN_EN
  // Period-start pulse register.
  always_ff @(posedge pll_clk_out or negedge arst_l) begin
    if (!arst_l) begin
      align_reg <= 1'b0;
    end else begin
      align_reg <= align_next;
    end
  end

  assign div_align = align_reg;
`endif

  assign div0       = div0_reg;
  assign div1       = div1_reg;
  assign cfg_err    = cfg_err_reg;
  assign cfg_rdy    = ~pend_reg;
  assign div_active = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_bw_ctu_clk_div_gen.sv
// Self-checking bench for bw_ctu_clk_div_gen. A behavioural model (period
// position, ratio, held ratio) predicts every output each cycle; directed
// scenarios pin the model with hand-computed output sequences, then a
// randomized phase exercises enables, configs and resets.
// Define BW_CTU_CLK_DIV_ALIGN_EN to also check div_align.
module tb_bw_ctu_clk_div_gen;

  logic       pll_clk_out = 1'b0;
  logic       arst_l      = 1'b0;
  logic       div_en      = 1'b0;
  logic       cfg_vld     = 1'b0;
  logic [4:0] cfg_ratio   = 5'd0;
  logic       cfg_rdy, cfg_err, div0, div1, div_active;
`ifdef BW_CTU_CLK_DIV_ALIGN_EN
  logic       div_align;
  logic [31:0] g_al;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  // Behavioural model: is the divider producing, is it winding down,
  // position within the period, ratio in force, held ratio.
  bit m_on = 1'b0, m_stop = 1'b0, m_pend = 1'b0, m_err = 1'b0;
  int m_n = 2, m_pos = 0, m_pend_n = 0;

  logic [31:0] g_d0, g_d1, g_act, g_rdy;

  always #5 pll_clk_out = ~pll_clk_out;

  bw_ctu_clk_div_gen dut (
    .pll_clk_out (pll_clk_out),
    .arst_l      (arst_l),
    .div_en      (div_en),
    .cfg_vld     (cfg_vld),
    .cfg_ratio   (cfg_ratio),
    .cfg_rdy     (cfg_rdy),
    .cfg_err     (cfg_err),
    .div0        (div0),
    .div1        (div1),
    .div_active  (div_active)
`ifdef BW_CTU_CLK_DIV_ALIGN_EN
    ,
    .div_align   (div_align)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 1'b0; m_stop = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    m_n = 2; m_pos = 0; m_pend_n = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT samples.
  task automatic model_step();
    bit acc, lgl, last, fin;
    if (!arst_l) begin
      model_reset();
      return;
    end
    acc = cfg_vld && !m_pend;
    lgl = (cfg_ratio >= 5'd2);
    if (!m_on) begin
      if (acc && lgl) m_n = int'(cfg_ratio);
      if (div_en) begin
        m_on = 1'b1; m_stop = 1'b0; m_pos = 0;
      end
    end else begin
      last = (m_pos == m_n - 1);
      fin  = m_stop && !div_en && last;
      if (last) begin
        m_pos = 0;
        if (m_pend) begin
          m_n = m_pend_n; m_pend = 1'b0;
        end
      end else begin
        m_pos = m_pos + 1;
      end
      if (acc && lgl) begin
        m_pend = 1'b1; m_pend_n = int'(cfg_ratio);
      end
      if (fin) m_on = 1'b0;
      else     m_stop = !div_en;
    end
    m_err = acc && !lgl;
  endtask

  task automatic tick();
    @(posedge pll_clk_out);
    model_step();
    #1;
  endtask

  task automatic assert_reset();
    arst_l = 1'b0;
    model_reset();
  endtask

  task automatic do_reset();
    div_en = 1'b0; cfg_vld = 1'b0;
    assert_reset();
    tick(); tick();
    arst_l = 1'b1;
  endtask

  // Sample n cycles of outputs (bit i = cycle i), advancing one clock each.
  task automatic grab(input int n);
    g_d0 = '0; g_d1 = '0; g_act = '0; g_rdy = '0;
`ifdef BW_CTU_CLK_DIV_ALIGN_EN
    g_al = '0;
`endif
    for (int i = 0; i < n; i++) begin
      g_d0[i] = div0; g_d1[i] = div1; g_act[i] = div_active; g_rdy[i] = cfg_rdy;
`ifdef BW_CTU_CLK_DIV_ALIGN_EN
      g_al[i] = div_align;
`endif
      tick();
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    wait (cmp_on);
    forever begin
      @(negedge pll_clk_out);
      chk("div0", 32'(div0), 32'(m_on && (m_pos < m_n / 2)));
      chk("div1", 32'(div1), 32'(m_on && (m_pos < m_n / 2) && (m_n % 2 == 1)));
      chk("div_active", 32'(div_active), 32'(m_on));
      chk("cfg_rdy", 32'(cfg_rdy), 32'(!m_pend));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef BW_CTU_CLK_DIV_ALIGN_EN
      chk("div_align", 32'(div_align), 32'(m_on && (m_pos == 0)));
`endif
    end
  end

  initial begin
    tick();
    // Reset state.
    chk("rst_div0", 32'(div0), 32'd0);
    chk("rst_div1", 32'(div1), 32'd0);
    chk("rst_active", 32'(div_active), 32'd0);
    chk("rst_rdy", 32'(cfg_rdy), 32'd1);
    chk("rst_err", 32'(cfg_err), 32'd0);
    cmp_on = 1'b1;

    // N=2 straight out of reset.
    do_reset();
    div_en = 1'b1;
    tick();
    grab(8);
    chk("n2_div0", g_d0, 32'h55);
    chk("n2_div1", g_d1, 32'h00);
`ifdef BW_CTU_CLK_DIV_ALIGN_EN
    chk("n2_align", g_al, 32'h55);
`endif
    $display("scenario N=2 from reset done");

    // N=5 configured in IDLE.
    do_reset();
    cfg_vld = 1'b1; cfg_ratio = 5'd5;
    tick();
    cfg_vld = 1'b0; div_en = 1'b1;
    tick();
    grab(10);
    chk("n5_div0", g_d0, 32'h063);
    chk("n5_div1", g_d1, 32'h063);
`ifdef BW_CTU_CLK_DIV_ALIGN_EN
    chk("n5_align", g_al, 32'h021);
`endif
    $display("scenario N=5 in IDLE done");

    // N=4 running, ratio 6 offered at cnt=1.
    do_reset();
    cfg_vld = 1'b1; cfg_ratio = 5'd4;
    tick();
    cfg_vld = 1'b0; div_en = 1'b1;
    tick();
    tick();
    cfg_vld = 1'b1; cfg_ratio = 5'd6;
    tick();
    cfg_vld = 1'b0;
    grab(10);
    chk("n4to6_div0", g_d0, 32'h31C);
    chk("n4to6_rdy", g_rdy, 32'h3FC);
    $display("scenario N=4 to N=6 mid-period done");

    // Illegal ratio while running.
    cfg_vld = 1'b1; cfg_ratio = 5'd1;
    tick();
    cfg_vld = 1'b0;
    chk("bad_err_hi", 32'(cfg_err), 32'd1);
    chk("bad_rdy", 32'(cfg_rdy), 32'd1);
    tick();
    chk("bad_err_lo", 32'(cfg_err), 32'd0);
    $display("scenario illegal ratio done");

    // N=7: div_en dropped at cnt=2, period drains out.
    do_reset();
    cfg_vld = 1'b1; cfg_ratio = 5'd7;
    tick();
    cfg_vld = 1'b0; div_en = 1'b1;
    tick(); tick(); tick();
    div_en = 1'b0;
    tick();
    grab(5);
    chk("drain_act", g_act, 32'h0F);
    chk("drain_div0", g_d0, 32'h00);
    // Restart, drop at cnt=2, re-raise at cnt=4.
    div_en = 1'b1;
    tick(); tick(); tick();
    div_en = 1'b0;
    tick(); tick();
    div_en = 1'b1;
    tick();
    grab(8);
    chk("resume_div0", g_d0, 32'h1C);
    chk("resume_div1", g_d1, 32'h1C);
    chk("resume_act", g_act, 32'hFF);
    $display("scenario N=7 drain and resume done");

    // N=8 with a held ratio, reset at cnt=3.
    do_reset();
    cfg_vld = 1'b1; cfg_ratio = 5'd8;
    tick();
    cfg_vld = 1'b0; div_en = 1'b1;
    tick();
    cfg_vld = 1'b1; cfg_ratio = 5'd3;
    tick();
    cfg_vld = 1'b0;
    chk("held_rdy", 32'(cfg_rdy), 32'd0);
    tick(); tick();
    chk("cnt3_div0", 32'(div0), 32'd1);
    assert_reset();
    #1;
    chk("arst_div0", 32'(div0), 32'd0);
    chk("arst_div1", 32'(div1), 32'd0);
    chk("arst_act", 32'(div_active), 32'd0);
    chk("arst_rdy", 32'(cfg_rdy), 32'd1);
    tick();
    arst_l = 1'b1;
    tick();
    grab(4);
    chk("post_rst_div0", g_d0, 32'h5);
    chk("post_rst_rdy", g_rdy, 32'hF);
    $display("scenario async reset with held ratio done");

    // Randomized phase.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) div_en = ~div_en;
      cfg_vld = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) cfg_ratio = 5'($urandom_range(0, 1));
      else if ($urandom_range(0, 7) == 0) cfg_ratio = 5'($urandom_range(2, 31));
      else cfg_ratio = 5'($urandom_range(2, 9));
      if (!arst_l) arst_l = 1'b1;
      else if ($urandom_range(0, 499) == 0) assert_reset();
      tick();
    end
    arst_l = 1'b1;
    cfg_vld = 1'b0;
    tick(); tick();
    $display("random phase done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bw_ctu_clk_div_gen.md
BW_CTU_CLK_DIV_GEN -- requirements
Module: bw_ctu_clk_div_gen

Interface
REQ-001 SHALL have parameter: CNT_W, 5, width of ratio and count (legal ratio 2..2^CNT_W-1).
REQ-002 SHALL have parameter: RST_RATIO, 2, divide ratio loaded at reset.
REQ-003 SHALL have port: pll_clk_out  in  1  PLL clock; sole clock; all flops on posedge.
REQ-004 SHALL have port: arst_l  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port: div_en  in  1  level request to run the divider.
REQ-006 SHALL have port: cfg_vld  in  1  new ratio offered.
REQ-007 SHALL have port: cfg_ratio  in  CNT_W  offered divide ratio N.
REQ-008 SHALL have port: cfg_rdy  out  1  ratio can be accepted.
REQ-009 SHALL have port: cfg_err  out  1  one-cycle pulse; illegal ratio rejected.
REQ-010 SHALL have port: div0  out  1  posedge-phase enable; feeds the sync-mux in0 input.
REQ-011 SHALL have port: div1  out  1  half-cycle-extension enable; feeds the sync-mux in1 input.
REQ-012 SHALL have port: div_active  out  1  high in RUN or DRAIN.
REQ-013 SHALL have port (macro-gated): div_align  out  1  one-cycle pulse in each period's cycle where cnt==0.

Function
REQ-014 SHALL hold registered cur_ratio N, count cnt (CNT_W bits), pending ratio, and pend flag.
REQ-015 SHALL implement FSM IDLE, RUN, DRAIN.
- IDLE->RUN: cycle after div_en sampled 1.
- RUN->DRAIN: div_en sampled 0.
- DRAIN->RUN: div_en sampled 1; count continues, no phase break.
- DRAIN->IDLE: at wrap.
REQ-016 In RUN/DRAIN, cnt SHALL increment each cycle; at cnt==N-1, cnt SHALL wrap to 0.
REQ-017 The first RUN cycle SHALL have cnt=0.
REQ-018 With H=N>>1, in the cycle cnt==k: div0=(k<H) and div1=(k<H)&N[0].
- Downstream OR of posedge/negedge captures then gives 50% duty: H cycles high for even N, H+0.5 for odd N.
REQ-019 div0 and div1 SHALL be direct flop outputs with no combinational path from inputs.
REQ-020 In IDLE, div0, div1 and div_align SHALL be 0 and cnt SHALL be 0.
REQ-021 A ratio SHALL be accepted when cfg_vld & cfg_rdy; cfg_rdy = ~pend.
REQ-022 An accepted cfg_ratio<2 SHALL be discarded, with cfg_err=1 in the following cycle and no state change.
REQ-023 A legal ratio accepted in IDLE SHALL become N in the next cycle.
REQ-024 A legal ratio accepted in RUN/DRAIN SHALL set pend and be applied at the next wrap: the cycle with cnt==0 uses the new N.
- pend clears at that point; cfg_rdy rises in the same cycle.
REQ-025 If acceptance and wrap coincide, the new ratio SHALL be applied at the following wrap, never mid-period.
REQ-026 If div_en falls while pend is set, the pending ratio SHALL still be applied on DRAIN->IDLE.

Reset
REQ-027 On arst_l low, asynchronously:
- state=IDLE, cnt=0, N=RST_RATIO, pend=0.
- cfg_rdy=1; div0=div1=div_active=cfg_err=div_align=0.
REQ-028 Reset mid-period SHALL force the outputs low immediately; operation resumes only after deassertion plus div_en sampled 1.

Configuration
REQ-029 Macro BW_CTU_CLK_DIV_ALIGN_EN:
- Defined: div_align port and its flop are present per REQ-013.
- Undefined: no div_align port and no align logic; all other behaviour is identical.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, CNT_W default, and the minimum-ratio constant (2).
REQ-031 Counter, FSM and config handshake SHALL live in one module, with no sub-module.

Verification
REQ-032 Reset, div_en=1, N=2: div0 pattern 1,0,1,0...; div1=0; div_align every 2nd cycle.
REQ-033 cfg N=5 in IDLE, then div_en=1: div0=1,1,0,0,0 repeating; div1=1,1,0,0,0; div_align at cnt=0.
REQ-034 RUN at N=4, cfg N=6 accepted at cnt=1:
- cfg_rdy low until wrap.
- Next period is 6 cycles with div0 high for 3.
- No short or long period.
REQ-035 cfg_ratio=1 offered: cfg_err pulses 1 cycle, N unchanged, cfg_rdy stays 1.
REQ-036 div_en drops at cnt=2 of N=7: period completes to cnt=6, then IDLE with outputs 0; re-raising div_en at cnt=4 continues the count without a break.
REQ-037 arst_l asserted at cnt=3 of N=8 with a pending ratio: outputs 0 immediately; after release, N=RST_RATIO and pend=0.
